// File: rtl/mips_pkg.sv
// Shared MIPS-core constants and types: zero-register index, default datapath widths,
// and the register-address and data-word types.
package mips_pkg;

    localparam int REG_ZERO   = 0;
    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;

    typedef logic [GRF_ADDR_W-1:0] reg_addr_t;
    typedef logic [GRF_DATA_W-1:0] word_t;

endpackage

// File: rtl/pipe_grf_if.sv
// Register-file access bundle: read ports, writeback port, issue/flush scoreboard controls.
// The master side belongs to the pipeline and the slave side to pipe_grf.
interface pipe_grf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [31:0]              wr_pc;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr, flush,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/grf_scoreboard.sv
// Pending-writer bit per register: flush clears all, writeback clears one, issue sets one
// (issue wins a same-address tie). Busy lookup hides a register being written this cycle.
module grf_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (wr_en && wr_addr != ZERO_ADDR) pend_d[wr_addr] = 1'b0;
            if (iss_en && iss_addr != ZERO_ADDR) pend_d[iss_addr] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // $0 is never set, so its lookup is always clear without a special case.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = pend_q[rd_addr[k*ADDR_W +: ADDR_W]]
                         && !(wr_en && wr_addr == rd_addr[k*ADDR_W +: ADDR_W]);
        end
    end

endmodule

// File: rtl/pipe_grf.sv
// MIPS general register file: NUM_RD combinational read ports with writeback bypass, one
// synchronous write port, pending-writer scoreboard. Define GRF_TRACE_EN for the write trace.
module pipe_grf
    import mips_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic       clk,
    input  logic       reset,
    pipe_grf_if.slave  bus
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_flat;

    always_comb begin
        mem_d = mem_q;
        if (bus.wr_en && bus.wr_addr != ZERO_ADDR) mem_d[bus.wr_addr] = bus.wr_data;
    end

    // NOTE: the array is reset on purpose: software may read a register before writing it,
    // so every entry must come out of reset as zero (this keeps it in flops, not RAM).
    always_ff @(posedge clk) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    // Zero-register check precedes the bypass, so a discarded write to $0 never leaks out.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data_flat[k*DATA_W +: DATA_W] =
            (addr == ZERO_ADDR)                     ? '0          :
            (bus.wr_en && bus.wr_addr == addr)      ? bus.wr_data :
                                                      mem_q[addr];
    end

    assign bus.rd_data = rd_data_flat;

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .flush    (bus.flush),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (bus.rd_busy)
    );

`ifdef GRF_TRACE_EN
    // Trace prints writes to $0 as well, matching the reference grading format.
    always_ff @(posedge clk) begin
        if (!reset && bus.wr_en) begin
            $display("@%h: $%d <= %h", bus.wr_pc, bus.wr_addr, bus.wr_data);
        end
    end
`else
    logic unused_wr_pc;
    assign unused_wr_pc = ^bus.wr_pc;
`endif

endmodule

// File: tb/tb_pipe_grf.sv
// Scoreboard bench for pipe_grf: driver pushes expected read results from an array model,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_grf;
    import mips_pkg::*;

    typedef struct {
        string      tag;
        word_t      d0;
        word_t      d1;
        logic [1:0] busy;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    exp_t  sb_q[$];
    word_t regs[32];
    bit    pend[32];

    always #5 clk = ~clk;

    pipe_grf_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    pipe_grf #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic word_t exp_read(reg_addr_t a, bit we, reg_addr_t wa, word_t wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return regs[a];
    endfunction

    function automatic bit exp_busy(reg_addr_t a, bit we, reg_addr_t wa);
        return (a != 0) && pend[a] && !(we && wa == a);
    endfunction

    // One clock of stimulus: apply inputs, queue the expected reads, then advance the model
    // to the state the next rising edge should produce.
    task automatic cycle(input string tag, input bit rst,
                         input bit we, input reg_addr_t wa, input word_t wd,
                         input bit ie, input reg_addr_t ia, input bit fl,
                         input reg_addr_t r0, input reg_addr_t r1);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        reset        = rst;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.wr_pc    = 32'h0040_3000 + 32'(cyc * 4);
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        bus.flush    = fl;
        bus.rd_addr  = {r1, r0};
        if (!rst) begin
            e.tag  = tag;
            e.d0   = exp_read(r0, we, wa, wd);
            e.d1   = exp_read(r1, we, wa, wd);
            e.busy = {exp_busy(r1, we, wa), exp_busy(r0, we, wa)};
            sb_q.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] = '0;
                pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) regs[wa] = wd;
            if (fl) begin
                for (int i = 0; i < 32; i++) pend[i] = 1'b0;
            end else begin
                if (we && wa != 0) pend[wa] = 1'b0;
                if (ie && ia != 0) pend[ia] = 1'b1;
            end
        end
    endtask

    task automatic idle(input string tag, input reg_addr_t r0, input reg_addr_t r1);
        cycle(tag, 0, 0, 0, '0, 0, 0, 0, r0, r1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.tag, " rd_data0"}, bus.rd_data[31:0], e.d0);
                check({e.tag, " rd_data1"}, bus.rd_data[63:32], e.d1);
                check({e.tag, " rd_busy"}, 32'(bus.rd_busy), 32'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit        we, ie, fl, rst, narrow;
        reg_addr_t wa, ia, r0, r1;
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_pc    = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.flush    = 1'b0;
        bus.rd_addr  = '0;

        cycle("reset", 1, 0, 0, '0, 0, 0, 0, 0, 0);
        idle("after_reset", 5, 31);
        cycle("write_r0", 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        idle("read_r0", 0, 0);
        cycle("bypass_r8", 0, 1, 8, 32'h1234_5678, 0, 0, 0, 8, 0);
        idle("stored_r8", 8, 8);
        cycle("issue_r9", 0, 0, 0, '0, 1, 9, 0, 9, 0);
        idle("busy_r9", 9, 9);
        cycle("wb_r9", 0, 1, 9, 32'hA5A5_A5A5, 0, 0, 0, 9, 9);
        idle("clear_r9", 9, 0);
        cycle("issue_r10", 0, 0, 0, '0, 1, 10, 0, 10, 0);
        cycle("wb_issue_r10", 0, 1, 10, 32'h1010_1010, 1, 10, 0, 10, 0);
        idle("rebusy_r10", 10, 10);
        cycle("issue_r3", 0, 0, 0, '0, 1, 3, 0, 3, 0);
        cycle("issue_r4", 0, 0, 0, '0, 1, 4, 0, 3, 4);
        cycle("issue_r7", 0, 0, 0, '0, 1, 7, 0, 4, 7);
        cycle("flush_iss12", 0, 0, 0, '0, 1, 12, 1, 3, 4);
        idle("post_flush_a", 3, 4);
        idle("post_flush_b", 7, 12);
        idle("post_flush_data", 8, 9);
        cycle("issue_r0", 0, 0, 0, '0, 1, 0, 0, 0, 0);
        idle("r0_not_busy", 0, 0);
        cycle("write_r6", 0, 1, 6, 32'h0000_0055, 0, 0, 0, 6, 0);
        cycle("reset_r6", 1, 1, 6, 32'h0000_0077, 1, 6, 0, 6, 0);
        idle("after_reset_r6", 6, 8);

        for (int n = 0; n < 400; n++) begin
            narrow = ($urandom_range(0, 1) == 1);
            wa  = narrow ? reg_addr_t'($urandom_range(0, 7)) : reg_addr_t'($urandom_range(0, 31));
            ia  = narrow ? reg_addr_t'($urandom_range(0, 7)) : reg_addr_t'($urandom_range(0, 31));
            r0  = narrow ? reg_addr_t'($urandom_range(0, 7)) : reg_addr_t'($urandom_range(0, 31));
            r1  = narrow ? reg_addr_t'($urandom_range(0, 7)) : reg_addr_t'($urandom_range(0, 31));
            we  = ($urandom_range(0, 1) == 1);
            ie  = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle("random", rst, we, wa, $urandom, ie, ia, fl, r0, r1);
        end

        idle("final", 0, 0);
        for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_grf.md
Name: pipe_grf

Overview:
- Parametrised general-purpose register file for the pipelined MIPS core.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Same-cycle write-to-read bypass, so decode sees writeback data without a separate forwarding path.
- Per-register pending (scoreboard) bits: set when an instruction naming a destination issues, cleared at its writeback; drive rd_busy to the hazard unit.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data; port k at [k*DATA_W +: DATA_W].
- rd_busy  output  NUM_RD  port k source register has an outstanding writer.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_pc  input  32  PC of the writing instruction (trace only).
- iss_en  input  1  issue strobe; marks iss_addr pending.
- iss_addr  input  ADDR_W  destination of the issuing instruction.
- flush  input  1  clears all pending bits (pipeline flush).

Behaviour:
- Reset (clk, reset synchronous active-high): on a rising edge with reset=1, all registers are set to 0 and all pending bits to 0.
  - wr_en, iss_en and flush are ignored in that cycle.
  - After reset, rd_data is all zeros and rd_busy is all zeros.
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - It is never pending; iss_addr=0 is ignored.
- Write: when wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data at the rising edge.
- Read: combinational, zero latency.
  - rd_data[k] = 0 if rd_addr[k]=0.
  - Otherwise, if wr_en && wr_addr==rd_addr[k], rd_data[k] = wr_data (bypass).
  - Otherwise rd_data[k] = mem[rd_addr[k]].
  - Multiple ports may read the same address.
- Pending bits pend[1..2**ADDR_W-1], updated each edge (reset=0) in this priority order:
  1. flush=1: all bits cleared. A simultaneous iss_en is also dropped; the flush kills the issuing instruction.
  2. Otherwise, wr_en && wr_addr!=0 clears pend[wr_addr].
  3. Then, iss_en && iss_addr!=0 sets pend[iss_addr]. Set wins over a same-address clear in the same cycle, because the newer writer is now outstanding.
- rd_busy[k] = pend[rd_addr[k]] && !(wr_en && wr_addr==rd_addr[k]).
  - The write in progress satisfies the read through the bypass.
  - rd_busy does not reflect a same-cycle iss_en; the issuing instruction is younger than the reader.
  - rd_busy[k] = 0 for address 0.
- Single outstanding writer per register is the pipeline's contract. A second iss_en to a pending address simply leaves the bit set; there is no counter.
- wr_en with wr_addr not pending is legal: the write happens and pending stays 0.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: on every clock edge with reset=0 and wr_en=1, print "@%h: $%d <= %h" with wr_pc, wr_addr, wr_data.
  - The line is printed even when wr_addr=0, matching the grading trace format.
  - Simulation-only; no effect on logic.
- Undefined: no display statement compiled; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ZERO = 0.
  - Default DATA_W = 32 and ADDR_W = 5.
  - typedef reg_addr_t (ADDR_W bits) and typedef word_t (DATA_W bits).
- One sub-module, grf_scoreboard: pending-bit array, flush/clear/set priority and busy lookup, instantiated once.
- Storage and bypass muxes stay in pipe_grf, one generate loop over NUM_RD.

Test Plan:
- Reset, then read ports 0/1 at addrs 5 and 31 -> rd_data=0, rd_busy=0; write 0xDEADBEEF to $0, read $0 -> 0.
- wr_en=1, wr_addr=8, wr_data=0x12345678 with rd_addr[0]=8 in the same cycle -> rd_data[0]=0x12345678 combinationally; next cycle without write, still 0x12345678.
- iss_en on $9, next cycle read $9 -> rd_busy=1; writeback $9=0xA5A5A5A5 -> that cycle rd_busy=0, rd_data=0xA5A5A5A5; next cycle pend[9]=0.
- Same cycle: wr_en on $10 (pending) and iss_en on $10 -> next cycle rd_busy for $10 = 1.
- Set pending on $3, $4, $7; assert flush together with iss_en on $12 -> next cycle all rd_busy=0 including $12; register contents unchanged.
- Write $6=0x55, then reset=1 for one cycle with wr_en on $6=0x77 -> $6 reads 0, no pending. With GRF_TRACE_EN, the pre-reset write prints "@<pc>: $ 6 <= 00000055"; nothing prints in the reset cycle.
